// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between the lab-side requesters, the arbiter and the SDRAM
// controller client port (addr1/din1/dout1/wrl1/wrh1/req1/ack1).
// master: the arbiter's view. slave: the requesters plus controller.
`timescale 1ns/1ps
interface sdram_port_arbiter_if #(
  parameter int n_req  = 3,
  parameter int w_addr = 24,
  parameter int w_data = 16
);
  // requester side
  logic [n_req-1:0]        req;
  logic [n_req*w_addr-1:0] addr;
  logic [n_req*w_data-1:0] wdata;
  logic [n_req-1:0]        wrl;
  logic [n_req-1:0]        wrh;
  logic [w_data-1:0]       rdata;
  logic [n_req-1:0]        done;
  logic                    busy;
  // controller side
  logic [w_addr-1:0]       ram_addr;
  logic [w_data-1:0]       ram_wdata;
  logic                    ram_wrl;
  logic                    ram_wrh;
  logic                    ram_req;
  logic                    ram_ack;
  logic [w_data-1:0]       ram_rdata;

  modport master (
    input  req, addr, wdata, wrl, wrh, ram_ack, ram_rdata,
    output rdata, done, busy, ram_addr, ram_wdata, ram_wrl, ram_wrh, ram_req
  );

  modport slave (
    output req, addr, wdata, wrl, wrh, ram_ack, ram_rdata,
    input  rdata, done, busy, ram_addr, ram_wdata, ram_wrl, ram_wrh, ram_req
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake SDRAM controller port
// among n_req requesters; one controller transaction in flight at a time.
// Optional macro SDRAM_ARB_PRIORITY0_EN: requester 0 gets fixed highest
// priority and the round-robin pointer only rotates over requesters 1..n-1.
`timescale 1ns/1ps
module sdram_port_arbiter #(
  parameter int n_req  = 3,
  parameter int w_addr = 24,
  parameter int w_data = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sdram_port_arbiter_if.master bus
);
  localparam int w_idx = (n_req > 1) ? $clog2(n_req) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [w_idx-1:0]  r_ptr;
  logic [w_idx-1:0]  r_grant;
  logic              r_ram_req;
  logic [w_addr-1:0] r_ram_addr;
  logic [w_data-1:0] r_ram_wdata;
  logic              r_ram_wrl;
  logic              r_ram_wrh;
  logic [w_data-1:0] r_rdata;

  logic [n_req-1:0]  w_req_elig;
  logic [w_idx-1:0]  w_rr_idx [n_req];
  logic [w_idx-1:0]  w_grant;
  logic              w_grant_vld;
  logic              w_ack_match;
  logic [w_idx-1:0]  w_grant_inc;
  logic [w_idx-1:0]  w_ptr_next;
  logic [n_req-1:0]  w_done;
  logic              w_busy;

  assign w_ack_match = (bus.ram_ack == r_ram_req);
  assign w_grant_inc = (r_grant == w_idx'(n_req - 1)) ? '0 : r_grant + w_idx'(1);

`ifdef SDRAM_ARB_PRIORITY0_EN
  // Requester 0 masks everyone else; without it, bit 0 is already clear so
  // the rotating search only ever sees requesters 1..n-1.
  assign w_req_elig = bus.req[0] ? {{(n_req-1){1'b0}}, 1'b1} : bus.req;
  // A priority grant to requester 0 must not disturb the rotation of the rest.
  assign w_ptr_next = (r_grant == '0) ? r_ptr : w_grant_inc;
`else
  assign w_req_elig = bus.req;
  assign w_ptr_next = w_grant_inc;
`endif

  // Search order: ptr, ptr+1, ... wrapping modulo n_req.
  for (genvar gi = 0; gi < n_req; gi++) begin : g_rr
    assign w_rr_idx[gi] = w_idx'((32'(r_ptr) + 32'(gi)) % 32'(n_req));
  end

  // First eligible requester at or after the pointer wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = r_ptr;
    for (int k = 0; k < n_req; k++) begin
      if (!w_grant_vld && w_req_elig[w_rr_idx[k]]) begin
        w_grant_vld = 1'b1;
        w_grant     = w_rr_idx[k];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: no timeout in WAIT, DONE always returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_vld) w_state_next = S_WAIT;
      S_WAIT:  if (w_ack_match) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state: done pulses for the whole DONE cycle only.
  always_comb begin
    w_done = '0;
    w_busy = (r_state != S_IDLE);
    if (r_state == S_DONE) begin
      w_done[r_grant] = 1'b1;
    end
  end

  // Datapath: latch the winner's slice on grant, capture read data on ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_grant     <= '0;
      r_ram_req   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_wrl   <= 1'b0;
      r_ram_wrh   <= 1'b0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_grant     <= w_grant;
            r_ram_addr  <= bus.addr[32'(w_grant) * w_addr +: w_addr];
            r_ram_wdata <= bus.wdata[32'(w_grant) * w_data +: w_data];
            r_ram_wrl   <= bus.wrl[w_grant];
            r_ram_wrh   <= bus.wrh[w_grant];
            r_ram_req   <= ~r_ram_req;
          end
        end
        S_WAIT: begin
          if (w_ack_match) begin
            r_rdata <= bus.ram_rdata;
            r_ptr   <= w_ptr_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.rdata     = r_rdata;
  assign bus.done      = w_done;
  assign bus.busy      = w_busy;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.ram_wrl   = r_ram_wrl;
  assign bus.ram_wrh   = r_ram_wrh;
  assign bus.ram_req   = r_ram_req;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a toggle-handshake controller
// model whose acknowledge latency is set per transaction.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
  localparam int N  = 3;
  localparam int WA = 24;
  localparam int WD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.n_req(N), .w_addr(WA), .w_data(WD)) bus ();

  sdram_port_arbiter #(.n_req(N), .w_addr(WA), .w_data(WD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: acks lat clock edges after it first sees the toggle.
  int          lat = 5;
  logic [15:0] rd_val = 16'h0;
  int          cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      bus.ram_ack   <= 1'b0;
      bus.ram_rdata <= '0;
      cnt = 0;
    end else if (bus.ram_req != bus.ram_ack) begin
      cnt = cnt + 1;
      if (cnt >= lat) begin
        bus.ram_ack   <= bus.ram_req;
        bus.ram_rdata <= rd_val;
        cnt = 0;
      end
    end else begin
      cnt = 0;
    end
  end

  // One line per completed transaction.
  always @(negedge clk) begin
    if (!rst && bus.done != '0) begin
      n_done++;
      $display("txn done=%b rdata=%h addr=%h cyc=%0d", bus.done, bus.rdata, bus.ram_addr, cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_toggle(input string tag, output int c);
    logic prev;
    bit   seen;
    prev = bus.ram_req;
    seen = 1'b0;
    c    = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.ram_req !== prev) begin
        seen = 1'b1;
        c    = cyc;
      end
    end
    if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string tag, output int c, output logic [2:0] d);
    bit seen;
    seen = 1'b0;
    c    = -1;
    d    = '0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        seen = 1'b1;
        c    = cyc;
        d    = bus.done;
      end
    end
    if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          t0, td, tprev, nd0, busy_low;
    logic [2:0]  d, e;
    logic        tog;
    bit          seen;
    int          exp_g [6];

    bus.req   = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.wrl   = '0;
    bus.wrh   = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values.
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_ram_req", bus.ram_req, 0);
    check_eq("rst_ram_addr", bus.ram_addr, 0);
    check_eq("rst_rdata", bus.rdata, 0);
    check_eq("rst_ram_wr", {bus.ram_wrh, bus.ram_wrl}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single read from requester 0, ack 5 edges after the toggle.
    lat    = 5;
    rd_val = 16'hBEEF;
    bus.addr[0*WA +: WA] = 24'h001234;
    bus.req = 3'b001;
    wait_toggle("t1_tog", t0);
    check_eq("t1_ram_addr", bus.ram_addr, 24'h001234);
    check_eq("t1_busy", bus.busy, 1);
    check_eq("t1_ram_wr", {bus.ram_wrh, bus.ram_wrl}, 0);
    wait_done("t1_done", td, d);
    check_eq("t1_latency", td - t0, 6);
    check_eq("t1_done", d, 3'b001);
    check_eq("t1_rdata", bus.rdata, 16'hBEEF);
    bus.req = '0;
    @(negedge clk);
    check_eq("t1_done_one_cycle", bus.done, 0);
    check_eq("t1_idle", bus.busy, 0);
    check_eq("t1_single_toggle", bus.ram_req, 1);

    // Low-byte write from requester 2.
    lat    = 2;
    rd_val = 16'h1111;
    bus.addr[2*WA +: WA]  = 24'h000042;
    bus.wdata[2*WD +: WD] = 16'hA55A;
    bus.wrl = 3'b100;
    bus.wrh = 3'b000;
    bus.req = 3'b100;
    wait_toggle("t2_tog", t0);
    check_eq("t2_ram_wdata", bus.ram_wdata, 16'hA55A);
    check_eq("t2_ram_wrl", bus.ram_wrl, 1);
    check_eq("t2_ram_wrh", bus.ram_wrh, 0);
    check_eq("t2_ram_addr", bus.ram_addr, 24'h000042);
    wait_done("t2_done", td, d);
    check_eq("t2_done", d, 3'b100);
    bus.req = '0;
    bus.wrl = '0;
    repeat (3) @(negedge clk);

    // Contention: all three held, 3-edge ack, six transactions.
`ifdef SDRAM_ARB_PRIORITY0_EN
    exp_g = '{0, 0, 0, 1, 2, 1};
`else
    exp_g = '{0, 1, 2, 0, 1, 2};
`endif
    lat   = 3;
    nd0   = n_done;
    tprev = 0;
    rd_val = 16'hC000;
    bus.req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      wait_done($sformatf("t3_done%0d", i), td, d);
      e = 3'b001 << exp_g[i];
      check_eq($sformatf("t3_grant%0d", i), d, e);
      check_eq($sformatf("t3_rdata%0d", i), bus.rdata, 16'hC000 + 16'(i));
      if (i > 0) check_eq($sformatf("t3_spacing%0d", i), td - tprev, 6);
      tprev  = td;
      rd_val = 16'hC000 + 16'(i + 1);
`ifdef SDRAM_ARB_PRIORITY0_EN
      if (i == 2) bus.req = 3'b110;
`endif
      if (i == 5) bus.req = 3'b000;
    end
    repeat (8) @(negedge clk);
    check_eq("t3_idle", bus.busy, 0);
    check_eq("t3_done_count", n_done - nd0, 6);

    // Reset two cycles after the toggle aborts the transaction.
    lat    = 10;
    rd_val = 16'h9999;
    bus.addr[1*WA +: WA]  = 24'h000ABC;
    bus.wdata[1*WD +: WD] = 16'h5555;
    bus.req = 3'b010;
    wait_toggle("t5_tog", t0);
    repeat (2) @(negedge clk);
    rst     = 1'b1;
    bus.req = '0;
    @(negedge clk);
    check_eq("t5_busy", bus.busy, 0);
    check_eq("t5_ram_req", bus.ram_req, 0);
    check_eq("t5_ram_addr", bus.ram_addr, 0);
    check_eq("t5_ram_wdata", bus.ram_wdata, 0);
    check_eq("t5_rdata", bus.rdata, 0);
    check_eq("t5_done", bus.done, 0);
    rst = 1'b0;
    nd0 = n_done;
    repeat (12) @(negedge clk);
    check_eq("t5_no_done", n_done - nd0, 0);
    lat    = 2;
    rd_val = 16'h2222;
    bus.req = 3'b010;
    wait_toggle("t5b_tog", t0);
    check_eq("t5b_ram_addr", bus.ram_addr, 24'h000ABC);
    wait_done("t5b_done", td, d);
    check_eq("t5b_done", d, 3'b010);
    check_eq("t5b_rdata", bus.rdata, 16'h2222);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Late ack with requester 1 holding req through DONE.
    lat    = 20;
    rd_val = 16'h6666;
    bus.addr[1*WA +: WA] = 24'h000100;
    bus.req = 3'b010;
    wait_toggle("t6_tog", t0);
    busy_low = 0;
    seen     = 1'b0;
    td       = -1;
    d        = '0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        seen = 1'b1;
        td   = cyc;
        d    = bus.done;
      end else if (!bus.busy) begin
        busy_low++;
      end
    end
    if (!seen) check_eq("t6_done_timeout", 32'd0, 32'd1);
    check_eq("t6_busy_held", busy_low, 0);
    check_eq("t6_latency", td - t0, 21);
    check_eq("t6_done", d, 3'b010);
    check_eq("t6_rdata", bus.rdata, 16'h6666);
    lat    = 2;
    rd_val = 16'h7777;
    bus.addr[1*WA +: WA] = 24'h000777;
    tog = bus.ram_req;
    @(negedge clk);
    check_eq("t6_no_grant_from_done", bus.ram_req, tog);
    check_eq("t6_idle_gap", bus.busy, 0);
    @(negedge clk);
    check_eq("t6_regrant", bus.ram_req, !tog);
    check_eq("t6_ram_addr2", bus.ram_addr, 24'h000777);
    wait_done("t6b_done", td, d);
    check_eq("t6b_done", d, 3'b010);
    check_eq("t6b_rdata", bus.rdata, 16'h7777);
    bus.req = '0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
